// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo up/down counter with clear, load, wrap pulse and sticky boundary flag
module mod_counter #(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             ovf_nxt;

    // Boundary depends on the live direction so up changes act on the same edge.
    assign tc = up ? (count == MAX) : (count == ZERO);

    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        ovf_nxt   = ovf;
        if (clr) begin
            count_nxt = ZERO;
            ovf_nxt   = 1'b0;
        end else if (load) begin
            count_nxt = (load_val > MAX) ? MAX : load_val;
        end else if (en) begin
            if (tc) begin
                ovf_nxt = 1'b1;
                if (!sat) begin
                    count_nxt = up ? ZERO : MAX;
                    wrap_nxt  = 1'b1;
                end
            end else begin
                count_nxt = up ? (count + ONE) : (count - ONE);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= ZERO;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
            ovf   <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - scoreboard bench for mod_counter at MODULUS=10 and MODULUS=16
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       sat = 1'b0;

    logic [3:0] count10, count16;
    logic       tc10, tc16, wrap10, wrap16, ovf10, ovf16;

    int n_assert = 0;
    int n_fail   = 0;

    mod_counter #(.WIDTH(4), .MODULUS(10)) u10 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .sat(sat),
        .count(count10), .tc(tc10), .wrap(wrap10), .ovf(ovf10)
    );

    mod_counter #(.WIDTH(4), .MODULUS(16)) u16 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .sat(sat),
        .count(count16), .tc(tc16), .wrap(wrap16), .ovf(ovf16)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c [2];
        bit w [2];
        bit o [2];
        bit t [2];
    } exp_t;

    exp_t sbq[$];
    int   md [2] = '{10, 16};
    int   mc [2] = '{0, 0};
    bit   mw [2] = '{0, 0};
    bit   mo [2] = '{0, 0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic bit model_tc(int i);
        return up ? (mc[i] == md[i] - 1) : (mc[i] == 0);
    endfunction

    task automatic model_step();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            mw[i] = 1'b0;
            if (!rst_n) begin
                mc[i] = 0;
                mo[i] = 1'b0;
            end else if (clr) begin
                mc[i] = 0;
                mo[i] = 1'b0;
            end else if (load) begin
                mc[i] = (int'(load_val) >= md[i]) ? md[i] - 1 : int'(load_val);
            end else if (en) begin
                if (up && mc[i] == md[i] - 1) begin
                    mo[i] = 1'b1;
                    if (!sat) begin mc[i] = 0; mw[i] = 1'b1; end
                end else if (!up && mc[i] == 0) begin
                    mo[i] = 1'b1;
                    if (!sat) begin mc[i] = md[i] - 1; mw[i] = 1'b1; end
                end else begin
                    mc[i] = up ? mc[i] + 1 : mc[i] - 1;
                end
            end
            e.c[i] = mc[i];
            e.w[i] = mw[i];
            e.o[i] = mo[i];
            e.t[i] = model_tc(i);
        end
        sbq.push_back(e);
    endtask

    task automatic tick(input string tag);
        exp_t e;
        model_step();
        @(posedge clk);
        #2;
        e = sbq.pop_front();
        chk({tag, " count10"}, 64'(count10), 64'(e.c[0]));
        chk({tag, " wrap10"},  64'(wrap10),  64'(e.w[0]));
        chk({tag, " ovf10"},   64'(ovf10),   64'(e.o[0]));
        chk({tag, " tc10"},    64'(tc10),    64'(e.t[0]));
        chk({tag, " count16"}, 64'(count16), 64'(e.c[1]));
        chk({tag, " wrap16"},  64'(wrap16),  64'(e.w[1]));
        chk({tag, " ovf16"},   64'(ovf16),   64'(e.o[1]));
        chk({tag, " tc16"},    64'(tc16),    64'(e.t[1]));
    endtask

    task automatic set_in(input bit c, input bit l, input logic [3:0] lv,
                          input bit e, input bit u, input bit s);
        clr = c; load = l; load_val = lv; en = e; up = u; sat = s;
    endtask

    task automatic async_reset_check(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, " rst count10"}, 64'(count10), 64'd0);
        chk({tag, " rst wrap10"},  64'(wrap10),  64'd0);
        chk({tag, " rst ovf10"},   64'(ovf10),   64'd0);
        chk({tag, " rst count16"}, 64'(count16), 64'd0);
        for (int i = 0; i < 2; i++) begin
            mc[i] = 0; mw[i] = 1'b0; mo[i] = 1'b0;
        end
    endtask

    initial begin
        // Power-on reset
        #1;
        chk("por count10", 64'(count10), 64'd0);
        chk("por wrap10",  64'(wrap10),  64'd0);
        chk("por ovf10",   64'(ovf10),   64'd0);
        chk("por tc10",    64'(tc10),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Count up through the wrap at MODULUS=10
        set_in(0, 0, 4'd0, 1, 1, 0);
        for (int k = 0; k < 12; k++) tick("up_wrap");

        // Saturating down at zero
        set_in(1, 0, 4'd0, 0, 1, 0);
        tick("clr");
        set_in(0, 0, 4'd0, 1, 0, 1);
        for (int k = 0; k < 3; k++) tick("sat_down");

        // Load clamp, then clr beating load
        set_in(0, 1, 4'd13, 0, 1, 0);
        tick("load_clamp");
        set_in(1, 1, 4'd13, 1, 1, 0);
        tick("clr_over_load");

        // Natural roll-over at MODULUS=16 in both directions
        set_in(0, 1, 4'd15, 0, 1, 0);
        tick("load15");
        set_in(0, 0, 4'd0, 1, 1, 0);
        tick("roll_up");
        set_in(0, 0, 4'd0, 1, 0, 0);
        tick("roll_down");

        // Up-saturate hold at the top
        set_in(0, 1, 4'd9, 0, 1, 1);
        tick("load9");
        set_in(0, 0, 4'd0, 1, 1, 1);
        tick("sat_up");

        // Asynchronous reset mid-count
        set_in(1, 0, 4'd0, 0, 1, 0);
        tick("clr2");
        set_in(0, 0, 4'd0, 1, 1, 0);
        for (int k = 0; k < 5; k++) tick("to5");
        chk("at5 count10", 64'(count10), 64'd5);
        async_reset_check("mid");
        tick("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        tick("post_rst");

        // Reset kills a live wrap pulse
        set_in(0, 1, 4'd9, 0, 1, 0);
        tick("load9b");
        set_in(0, 0, 4'd0, 1, 1, 0);
        tick("wrap_live");
        async_reset_check("wrapkill");
        @(negedge clk);
        rst_n = 1'b1;
        tick("post_rst2");

        // Random regression against the model
        for (int k = 0; k < 10000; k++) begin
            set_in(($urandom_range(15) == 0), ($urandom_range(7) == 0), 4'($urandom_range(15)),
                   ($urandom_range(3) != 0), 1'($urandom_range(1)), 1'($urandom_range(1)));
            tick("rand");
        end

        chk("sb empty", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
